// File: rtl/usr_pkg.sv
// Shared definitions for the command sequencer: op encodings, command layout
// and FSM state encoding.
package usr_pkg;

    localparam int OP_W       = 2;
    localparam int DEF_DATA_W = 4;
    localparam int DEF_CNT_W  = 3;
    localparam int DEF_DEPTH  = 4;

    typedef enum logic [OP_W-1:0] {
        OP_HOLD = 2'b00,
        OP_SHL  = 2'b01,
        OP_SHR  = 2'b10,
        OP_LOAD = 2'b11
    } op_e;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_e;

    // Reference layout at default widths; the FIFO stores {op, data, count} in this order.
    typedef struct packed {
        op_e                   op;
        logic [DEF_DATA_W-1:0] data;
        logic [DEF_CNT_W-1:0]  count;
    } cmd_t;

    localparam int DEF_CMD_W = $bits(cmd_t);

    function automatic int cmd_width(input int data_w, input int cnt_w);
        return OP_W + data_w + cnt_w;
    endfunction

endpackage

// File: rtl/usr_cmd_sequencer_if.sv
// Upstream command channel of the sequencer.
interface usr_cmd_sequencer_if #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 3
);
    import usr_pkg::*;

    // A command transfers on a rising edge where cmd_valid && cmd_ready; the
    // master holds its fields stable while waiting, and cmd_ready never
    // depends on cmd_valid.
    logic              cmd_valid;
    logic              cmd_ready;
    logic [OP_W-1:0]   cmd_op;
    logic [DATA_W-1:0] cmd_data;
    logic [CNT_W-1:0]  cmd_count;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_data,
        output cmd_count,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_data,
        input  cmd_count,
        output cmd_ready
    );

endinterface

// File: rtl/usr_cmd_fifo.sv
// Power-of-two command FIFO with occupancy count; push is ignored when full,
// pop is ignored when empty.
module usr_cmd_fifo #(
    parameter  int WIDTH = 9,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LW-1:0]    level_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o && !reset;
    assign do_pop  = pop_i && !empty_o && !reset;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/usr_cmd_sequencer.sv
// Queues shift-register commands and replays each one onto ctrl/d for
// count+1 consecutive cycles, chaining queued commands without gaps.
module usr_cmd_sequencer
    import usr_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    usr_cmd_sequencer_if.slave     cmd,
    output logic [OP_W-1:0]        ctrl,
    output logic [DATA_W-1:0]      d,
    output logic                   busy,
    output logic                   done,
    output logic [$clog2(DEPTH):0] fifo_level,
    output state_e                 dbg_state
);

    localparam int CMD_W = OP_W + DATA_W + CNT_W;

    state_e            state_q, state_d;
    logic [OP_W-1:0]   ctrl_q, ctrl_d;
    logic [DATA_W-1:0] d_q, d_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic              push, pop, load;
    logic              full, empty;
    logic              last_issue;
    logic [CMD_W-1:0]  push_cmd, head_cmd;
    logic [OP_W-1:0]   head_op;
    logic [DATA_W-1:0] head_data;
    logic [CNT_W-1:0]  head_count;

    assign cmd.cmd_ready = !full && !reset;
    assign push          = cmd.cmd_valid && !full && !reset;
    assign push_cmd      = {cmd.cmd_op, cmd.cmd_data, cmd.cmd_count};

    assign head_op    = head_cmd[CMD_W-1 -: OP_W];
    assign head_data  = head_cmd[CNT_W +: DATA_W];
    assign head_count = head_cmd[CNT_W-1:0];

    usr_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_data_i (push_cmd),
        .pop_i       (pop),
        .head_o      (head_cmd),
        .full_o      (full),
        .empty_o     (empty),
        .level_o     (fifo_level)
    );

    assign last_issue = (state_q == ISSUE) && (rem_q == '0);

    always_comb begin
        state_d = state_q;
        ctrl_d  = ctrl_q;
        d_d     = d_q;
        rem_d   = rem_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                ctrl_d = OP_HOLD;
                load   = !empty;
            end
            ISSUE: begin
                if (rem_q != '0) begin
                    rem_d = rem_q - CNT_W'(1);
                end else if (!empty) begin
                    load = 1'b1;
                end else begin
                    state_d = IDLE;
                    ctrl_d  = OP_HOLD;
                end
            end
            default: begin
                state_d = IDLE;
                ctrl_d  = OP_HOLD;
            end
        endcase
        // Loading the head covers both the start from IDLE and the gapless chain.
        if (load) begin
            state_d = ISSUE;
            ctrl_d  = head_op;
            d_d     = head_data;
            rem_d   = head_count;
        end
        pop = load;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ctrl_q  <= OP_HOLD;
            d_q     <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            d_q     <= d_d;
            rem_q   <= rem_d;
        end
    end

    assign ctrl      = ctrl_q;
    assign d         = d_q;
    assign done      = last_issue && !reset;
    assign busy      = ((state_q == ISSUE) || !empty) && !reset;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_usr_cmd_sequencer.sv
// Bench for usr_cmd_sequencer: fixed vector table, directed multi-cycle
// sequences and random traffic against an interval-schedule reference model.
module tb_usr_cmd_sequencer;
    import usr_pkg::*;

    localparam int DATA_W = 4;
    localparam int CNT_W  = 3;
    localparam int DEPTH  = 4;
    localparam int LW     = $clog2(DEPTH) + 1;
    localparam int SB_W   = 2 + DATA_W;

    logic              clk   = 1'b0;
    logic              reset = 1'b1;
    logic [1:0]        ctrl;
    logic [DATA_W-1:0] d;
    logic              busy;
    logic              done;
    logic [LW-1:0]     fifo_level;
    state_e            dbg_state;

    always #5 clk = ~clk;

    usr_cmd_sequencer_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) cmd_if ();

    usr_cmd_sequencer #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd        (cmd_if),
        .ctrl       (ctrl),
        .d          (d),
        .busy       (busy),
        .done       (done),
        .fifo_level (fifo_level),
        .dbg_state  (dbg_state)
    );

    // Each accepted command occupies the FIFO from push+1 to start-1 and
    // issues on [start, fin]; start = max(push+2, previous fin+1).
    typedef struct {
        int                push_c;
        int                start;
        int                fin;
        logic [1:0]        op;
        logic [DATA_W-1:0] data;
    } mcmd_t;

    typedef struct {
        logic [1:0]        op;
        logic [DATA_W-1:0] data;
        logic [CNT_W-1:0]  cnt;
        logic [1:0]        exp_ctrl;
        logic [DATA_W-1:0] exp_d;
        int                exp_len;
    } vec_t;

    mcmd_t           mq[$];
    logic [SB_W-1:0] exp_q[$];
    vec_t            vecs[6];
    int              prev_end = -1;
    int              cyc = 0;
    int              total = 0;
    int              bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int m_level(input int c);
        int n = 0;
        foreach (mq[i]) if (mq[i].push_c < c && c < mq[i].start) n++;
        return n;
    endfunction

    function automatic logic m_busy(input int c);
        logic b = 1'b0;
        foreach (mq[i]) if (mq[i].push_c < c && c <= mq[i].fin) b = 1'b1;
        return b;
    endfunction

    function automatic int m_active(input int c);
        int idx = -1;
        foreach (mq[i]) if (mq[i].start <= c && c <= mq[i].fin) idx = i;
        return idx;
    endfunction

    function automatic logic [DATA_W-1:0] m_d(input int c);
        logic [DATA_W-1:0] v = '0;
        foreach (mq[i]) if (mq[i].start <= c) v = mq[i].data;
        return v;
    endfunction

    task automatic drive(input logic rst, input logic v, input logic [1:0] op,
                         input logic [DATA_W-1:0] dat, input logic [CNT_W-1:0] cnt);
        @(negedge clk);
        reset            = rst;
        cmd_if.cmd_valid = v;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_data  = dat;
        cmd_if.cmd_count = cnt;
        #1;
    endtask

    task automatic advance();
        @(posedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 2'b00, '0, '0);
        chk("rst_ready", cmd_if.cmd_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        @(posedge clk);
        drive(1'b1, 1'b0, 2'b00, '0, '0);
        chk("rst_ctrl", ctrl, 2'b00);
        chk("rst_d", d, '0);
        chk("rst_level", fifo_level, '0);
        chk("rst_ready2", cmd_if.cmd_ready, 1'b0);
        chk("rst_busy2", busy, 1'b0);
        chk("rst_done2", done, 1'b0);
        chk("rst_state", dbg_state, IDLE);
        @(posedge clk);
        mq.delete();
        exp_q.delete();
        prev_end = -1;
        cyc = 0;
    endtask

    task automatic mcycle(input logic v, input logic [1:0] op, input logic [DATA_W-1:0] dat,
                          input logic [CNT_W-1:0] cnt, output logic pushed, output logic rdy_seen);
        int    idx;
        logic  exp_ready;
        logic  exp_done;
        logic [1:0] exp_ctrl;
        mcmd_t m;
        drive(1'b0, v, op, dat, cnt);
        exp_ready = (m_level(cyc) < DEPTH);
        idx       = m_active(cyc);
        exp_done  = 1'b0;
        exp_ctrl  = 2'b00;
        if (idx >= 0) begin
            exp_ctrl = mq[idx].op;
            exp_done = (mq[idx].fin == cyc);
        end
        rdy_seen = cmd_if.cmd_ready;
        chk("cmd_ready", cmd_if.cmd_ready, exp_ready);
        chk("fifo_level", fifo_level, m_level(cyc));
        chk("busy", busy, m_busy(cyc));
        chk("ctrl", ctrl, exp_ctrl);
        chk("d", d, m_d(cyc));
        chk("done", done, exp_done);
        if (exp_done) chk("done_order", {ctrl, d}, exp_q.pop_front());
        pushed = v && exp_ready;
        if (pushed) begin
            m.push_c = cyc;
            m.start  = (cyc + 2 > prev_end + 1) ? cyc + 2 : prev_end + 1;
            m.fin    = m.start + int'(cnt);
            m.op     = op;
            m.data   = dat;
            prev_end = m.fin;
            mq.push_back(m);
            exp_q.push_back({op, dat});
        end
        advance();
    endtask

    task automatic idle_cycles(input int n);
        logic p, r;
        for (int i = 0; i < n; i++) mcycle(1'b0, 2'b00, '0, '0, p, r);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       pushed;
        logic       rdy;
        logic       stall_seen;
        int         tries;
        logic [2:0] cnts[5];

        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = 2'b00;
        cmd_if.cmd_data  = '0;
        cmd_if.cmd_count = '0;

        vecs[0] = '{OP_LOAD, 4'hA, 3'd0, 2'b11, 4'hA, 1};
        vecs[1] = '{OP_LOAD, 4'h5, 3'd7, 2'b11, 4'h5, 8};
        vecs[2] = '{OP_SHL,  4'h9, 3'd2, 2'b01, 4'h9, 3};
        vecs[3] = '{OP_SHR,  4'h3, 3'd1, 2'b10, 4'h3, 2};
        vecs[4] = '{OP_HOLD, 4'h6, 3'd3, 2'b00, 4'h6, 4};
        vecs[5] = '{OP_SHR,  4'hF, 3'd7, 2'b10, 4'hF, 8};

        do_reset();

        // Single commands into an idle sequencer: one IDLE cycle, then the issue window.
        for (int v = 0; v < 6; v++) begin
            drive(1'b0, 1'b1, vecs[v].op, vecs[v].data, vecs[v].cnt);
            chk("tbl_ready", cmd_if.cmd_ready, 1'b1);
            advance();
            drive(1'b0, 1'b0, 2'b00, '0, '0);
            chk("tbl_wait_ctrl", ctrl, 2'b00);
            chk("tbl_wait_busy", busy, 1'b1);
            chk("tbl_wait_level", fifo_level, 1);
            advance();
            for (int k = 0; k < vecs[v].exp_len; k++) begin
                drive(1'b0, 1'b0, 2'b00, '0, '0);
                chk("tbl_ctrl", ctrl, vecs[v].exp_ctrl);
                chk("tbl_d", d, vecs[v].exp_d);
                chk("tbl_done", done, (k == vecs[v].exp_len - 1));
                chk("tbl_state", dbg_state, ISSUE);
                advance();
            end
            drive(1'b0, 1'b0, 2'b00, '0, '0);
            chk("tbl_after_ctrl", ctrl, 2'b00);
            chk("tbl_after_d", d, vecs[v].exp_d);
            chk("tbl_after_done", done, 1'b0);
            chk("tbl_after_busy", busy, 1'b0);
            advance();
        end

        // Back-to-back pair: 3 cycles of SHL then 2 of SHR with no gap.
        do_reset();
        mcycle(1'b1, OP_SHL, 4'h3, 3'd2, pushed, rdy);
        mcycle(1'b1, OP_SHR, 4'hC, 3'd1, pushed, rdy);
        idle_cycles(8);

        // Keep valid asserted behind a long command until the FIFO fills and drains.
        do_reset();
        cnts[0] = 3'd1; cnts[1] = 3'd0; cnts[2] = 3'd3; cnts[3] = 3'd2; cnts[4] = 3'd4;
        stall_seen = 1'b0;
        mcycle(1'b1, OP_LOAD, 4'h1, 3'd7, pushed, rdy);
        for (int k = 0; k < 5; k++) begin
            tries  = 0;
            pushed = 1'b0;
            while (!pushed && tries < 40) begin
                mcycle(1'b1, 2'(k % 4), 4'(k + 2), cnts[k], pushed, rdy);
                if (!rdy) stall_seen = 1'b1;
                tries++;
            end
            chk("full_push_accepted", pushed, 1'b1);
        end
        chk("full_ready_dropped", stall_seen, 1'b1);
        idle_cycles(40);
        chk("full_sb_drained", exp_q.size(), 0);

        // Random traffic.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            mcycle($urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)),
                   DATA_W'($urandom_range(0, 15)), CNT_W'($urandom_range(0, 7)), pushed, rdy);
        end
        idle_cycles(50);
        chk("rand_sb_drained", exp_q.size(), 0);

        // Reset in the 3rd cycle of an 8-cycle command with two more queued.
        do_reset();
        mcycle(1'b1, OP_LOAD, 4'h7, 3'd7, pushed, rdy);
        mcycle(1'b1, OP_SHL, 4'h1, 3'd0, pushed, rdy);
        mcycle(1'b1, OP_SHR, 4'h2, 3'd1, pushed, rdy);
        idle_cycles(1);
        drive(1'b0, 1'b0, 2'b00, '0, '0);
        chk("abort_pre_ctrl", ctrl, 2'b11);
        chk("abort_pre_level", fifo_level, 2);
        do_reset();
        idle_cycles(16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
